// File: rtl/nf10_axis_pkt_len_tagger.sv
// nf10_axis_pkt_len_tagger
// Store-and-forward AXI4-Stream stage. Whole packets are buffered, their byte
// count is accumulated from tstrb, and each packet is re-emitted with a tuser
// word carrying {dst port = 0, src port = C_SRC_PORT, len} on its first beat.
// Packets longer than the data FIFO are discarded in full and counted.
module nf10_axis_pkt_len_tagger #(
    parameter int                     C_AXIS_DATA_WIDTH  = 256,
    parameter int                     C_AXIS_TUSER_WIDTH = 128,
    parameter int                     C_LEN_WIDTH        = 16,
    parameter int                     C_SPT_WIDTH        = 8,
    parameter int                     C_DPT_WIDTH        = 8,
    parameter logic [C_SPT_WIDTH-1:0] C_SRC_PORT         = '0,
    parameter int                     C_DEPTH_LOG2       = 6,
    parameter int                     C_PKTS_LOG2        = 3
) (
    input  logic                            axi_aclk,
    input  logic                            axi_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            pkt_drop,
    output logic [31:0]                     drop_count
);

    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
    localparam int AW     = C_DEPTH_LOG2;
    localparam int PW     = C_DEPTH_LOG2 + 1;
    localparam int LW     = C_PKTS_LOG2;
    localparam int DEPTH  = 1 << AW;
    localparam int LDEPTH = 1 << LW;

    localparam logic [PW-1:0] MAX_BEATS = PW'(DEPTH);
    localparam logic [LW:0]   LEN_FULL  = (LW + 1)'(LDEPTH);
    localparam logic [LW:0]   LEN_ONE   = (LW + 1)'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    localparam logic [0:0] E_IDLE = 1'b0;
    localparam logic [0:0] E_SEND = 1'b1;

    function automatic logic [C_LEN_WIDTH-1:0] popcount(input logic [STRB_W-1:0] s);
        logic [C_LEN_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < STRB_W; i++) begin
            n = n + {{(C_LEN_WIDTH-1){1'b0}}, s[i]};
        end
        return n;
    endfunction

    function automatic logic [C_AXIS_TUSER_WIDTH-1:0] make_tuser(input logic [C_LEN_WIDTH-1:0] len);
        logic [C_AXIS_TUSER_WIDTH-1:0] t;
        t = '0;
        t[C_LEN_WIDTH-1:0]                         = len;
        t[C_LEN_WIDTH +: C_SPT_WIDTH]               = C_SRC_PORT;
        t[C_LEN_WIDTH+C_SPT_WIDTH +: C_DPT_WIDTH]   = '0;
        return t;
    endfunction

    // Storage: beats and per-packet lengths (data only, never reset)
    logic [C_AXIS_DATA_WIDTH-1:0] data_mem [0:DEPTH-1];
    logic [STRB_W-1:0]            strb_mem [0:DEPTH-1];
    logic                         last_mem [0:DEPTH-1];
    logic [C_LEN_WIDTH-1:0]       len_mem  [0:LDEPTH-1];

    // Control state
    logic [1:0]             in_state;
    logic                   ready_en;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          wr_commit;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          beat_cnt;
    logic [C_LEN_WIDTH-1:0] byte_cnt;
    logic [LW:0]            len_wr;
    logic [LW:0]            len_rd;
    logic [0:0]             eg_state;

    // Derived control
    logic [PW-1:0]          occupancy;
    logic [LW:0]            len_cnt;
    logic                   len_full;
    logic                   in_acc;
    logic                   in_store;
    logic [C_LEN_WIDTH-1:0] pkt_bytes;
    logic                   in_overflow;
    logic [AW-1:0]          rd_idx;
    logic [LW-1:0]          len_rd_idx;
    logic [LW-1:0]          len_rd_nidx;
    logic                   eg_hs;
    logic                   eg_first;
    logic                   eg_load;
    logic [C_LEN_WIDTH-1:0] first_len;

    assign occupancy   = wr_ptr - rd_ptr;
    assign len_cnt     = len_wr - len_rd;
    assign len_full    = (len_cnt == LEN_FULL);
    assign s_axis_tready = ready_en &&
                           ((in_state == S_DROP) || ((occupancy != MAX_BEATS) && !len_full));
    assign in_acc      = s_axis_tvalid && s_axis_tready;
    assign in_store    = in_acc && (in_state != S_DROP);
    assign pkt_bytes   = byte_cnt + popcount(s_axis_tstrb);
    assign in_overflow = !s_axis_tlast && ((beat_cnt + 1'b1) == MAX_BEATS);

    assign rd_idx      = rd_ptr[AW-1:0];
    assign len_rd_idx  = len_rd[LW-1:0];
    assign len_rd_nidx = len_rd[LW-1:0] + 1'b1;
    assign eg_hs       = m_axis_tvalid && m_axis_tready;
    assign eg_first    = (eg_state == E_IDLE) || m_axis_tlast;
    // A following packet can be launched on the tlast handshake only if its
    // length entry is already behind the one being retired.
    assign eg_load     = (eg_state == E_IDLE) ? (len_cnt != '0)
                                              : (eg_hs && (!m_axis_tlast || (len_cnt > LEN_ONE)));
    assign first_len   = (eg_state == E_IDLE) ? len_mem[len_rd_idx] : len_mem[len_rd_nidx];

    // Ingress FSM: speculative writes, commit on tlast, rewind and drop on overflow
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            in_state   <= S_IDLE;
            ready_en   <= 1'b0;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            beat_cnt   <= '0;
            byte_cnt   <= '0;
            len_wr     <= '0;
            pkt_drop   <= 1'b0;
            drop_count <= '0;
        end else begin
            ready_en <= 1'b1;
            pkt_drop <= 1'b0;
            case (in_state)
                S_IDLE, S_ACCUM: begin
                    if (in_store) begin
                        if (s_axis_tlast) begin
                            wr_ptr    <= wr_ptr + 1'b1;
                            wr_commit <= wr_ptr + 1'b1;
                            len_wr    <= len_wr + 1'b1;
                            beat_cnt  <= '0;
                            byte_cnt  <= '0;
                            in_state  <= S_IDLE;
                        end else if (in_overflow) begin
                            wr_ptr     <= wr_commit;
                            pkt_drop   <= 1'b1;
                            drop_count <= drop_count + 32'd1;
                            beat_cnt   <= '0;
                            byte_cnt   <= '0;
                            in_state   <= S_DROP;
                        end else begin
                            wr_ptr   <= wr_ptr + 1'b1;
                            beat_cnt <= beat_cnt + 1'b1;
                            byte_cnt <= pkt_bytes;
                            in_state <= S_ACCUM;
                        end
                    end
                end
                S_DROP: begin
                    if (in_acc && s_axis_tlast) begin
                        in_state <= S_IDLE;
                    end
                end
                default: in_state <= S_IDLE;
            endcase
        end
    end

    // Beat and length storage writes
    always_ff @(posedge axi_aclk) begin
        if (in_store) begin
            data_mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
            strb_mem[wr_ptr[AW-1:0]] <= s_axis_tstrb;
            last_mem[wr_ptr[AW-1:0]] <= s_axis_tlast;
        end
        if (in_store && s_axis_tlast) begin
            len_mem[len_wr[LW-1:0]] <= pkt_bytes;
        end
    end

    // Egress FSM: refill the output register on each handshake, pop length on tlast
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            eg_state      <= E_IDLE;
            rd_ptr        <= '0;
            len_rd        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else begin
            if (eg_hs && m_axis_tlast) begin
                len_rd <= len_rd + 1'b1;
            end
            if (eg_load) begin
                rd_ptr        <= rd_ptr + 1'b1;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= last_mem[rd_idx];
                m_axis_tuser  <= eg_first ? make_tuser(first_len) : '0;
                eg_state      <= E_SEND;
            end else if (eg_hs) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                m_axis_tuser  <= '0;
                eg_state      <= E_IDLE;
            end
        end
    end

    // Output data register, loaded alongside the control fields
    always_ff @(posedge axi_aclk) begin
        if (eg_load) begin
            m_axis_tdata <= data_mem[rd_idx];
            m_axis_tstrb <= strb_mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_nf10_axis_pkt_len_tagger.sv
// Scoreboard bench for nf10_axis_pkt_len_tagger: directed packets push their
// expected output beats into a queue; a monitor pops and compares on every
// egress handshake.
module tb_nf10_axis_pkt_len_tagger;

    localparam logic [7:0] SRC = 8'h5A;

    logic         clk = 1'b0;
    logic         axi_resetn = 1'b1;
    logic [255:0] s_tdata = '0;
    logic [31:0]  s_tstrb = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic         s_tlast = 1'b0;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tready = 1'b0;
    logic         m_tlast;
    logic         pkt_drop;
    logic [31:0]  drop_count;

    nf10_axis_pkt_len_tagger #(.C_SRC_PORT(SRC)) dut (
        .axi_aclk      (clk),
        .axi_resetn    (axi_resetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .pkt_drop      (pkt_drop),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    beat_t exp_q[$];
    beat_t e;
    int checks = 0;
    int failures = 0;
    int drop_pulses = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] mk_user(input int len);
        logic [127:0] u;
        u = '0;
        u[15:0]  = len[15:0];
        u[23:16] = SRC;
        return u;
    endfunction

    // Monitor: compare each egress handshake against the head of the queue
    always @(negedge clk) begin
        if (axi_resetn && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%0h required=none", m_tdata);
            end else begin
                e = exp_q.pop_front();
                check("out_data", m_tdata, e.d);
                check("out_strb", {224'd0, m_tstrb}, {224'd0, e.s});
                check("out_user", {128'd0, m_tuser}, {128'd0, e.u});
                check("out_last", {255'd0, m_tlast}, {255'd0, e.l});
            end
        end
    end

    always @(negedge clk) begin
        if (axi_resetn && pkt_drop) drop_pulses++;
    end

    task automatic send_beat(input logic [255:0] d, input logic [31:0] s, input logic l);
        int n;
        s_tdata  = d;
        s_tstrb  = s;
        s_tlast  = l;
        s_tvalid = 1'b1;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (s_tready) break;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL ingress_timeout actual=tready_low required=accept");
        end else begin
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int id, input int nb, input logic [31:0] lstrb,
                            input int exp_len, input bit keep);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b.d = {8{id[15:0], i[15:0]}};
            b.s = (i == nb - 1) ? lstrb : 32'hFFFF_FFFF;
            b.l = (i == nb - 1);
            b.u = (i == 0) ? mk_user(exp_len) : 128'd0;
            if (keep) exp_q.push_back(b);
            send_beat(b.d, b.s, b.l);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    logic [31:0] strb5 [0:8] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_0001,
                                 32'h8000_0000, 32'h0F0F_0F0F, 32'hFFFF_0000,
                                 32'h0000_00FF, 32'h5555_5555, 32'hAAAA_AAAA};
    int          len5  [0:8] = '{32, 16, 1, 1, 16, 16, 8, 16, 16};

    initial begin
        int seen;
        int v;
        int n;

        // Reset state
        #2 axi_resetn = 1'b0;
        #1;
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tuser", m_tuser, 0);
        check("rst_pkt_drop", pkt_drop, 0);
        check("rst_drop_count", drop_count, 0);
        repeat (3) @(posedge clk);
        #1 axi_resetn = 1'b1;
        @(posedge clk);
        #1;
        check("rel_s_tready", s_tready, 1);

        // Test 1: single full beat, len 32, output within two cycles
        m_tready = 1'b1;
        send_pkt(1, 1, 32'hFFFF_FFFF, 32, 1);
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (m_tvalid) seen = 1;
        end
        check("t1_latency", seen, 1);
        wait_drain("t1_drain");

        // Test 2: three beats, partial last, len 68
        send_pkt(2, 3, 32'h0000_000F, 68, 1);
        wait_drain("t2_drain");

        // Test 3: oversize 65-beat packet dropped, then 2-beat packet len 64
        send_pkt(3, 65, 32'hFFFF_FFFF, 0, 0);
        send_pkt(4, 2, 32'hFFFF_FFFF, 64, 1);
        wait_drain("t3_drain");
        check("t3_drop_pulses", drop_pulses, 1);
        check("t3_drop_count", drop_count, 1);

        // Test 4: exactly 64 beats with egress stalled, len 2048
        m_tready = 1'b0;
        send_pkt(5, 64, 32'hFFFF_FFFF, 2048, 1);
        check("t4_full_ready", s_tready, 0);
        m_tready = 1'b1;
        wait_drain("t4_drain");

        // Test 5: nine one-beat packets, length FIFO fills after eight
        m_tready = 1'b0;
        for (int k = 0; k < 8; k++) send_pkt(10 + k, 1, strb5[k], len5[k], 1);
        repeat (2) @(posedge clk);
        #1;
        check("t5_len_full_ready", s_tready, 0);
        fork
            send_pkt(18, 1, strb5[8], len5[8], 1);
            begin
                @(posedge clk);
                #1 m_tready = 1'b1;
                v = 0;
                repeat (8) begin
                    @(negedge clk);
                    if (m_tvalid) v++;
                end
                check("t5_back_to_back", v, 8);
            end
        join
        wait_drain("t5_drain");

        // Test 6: reset with a packet mid-egress and another mid-ingress
        m_tready = 1'b0;
        send_pkt(60, 3, 32'hFFFF_FFFF, 96, 1);
        n = 0;
        while (!m_tvalid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_valid", m_tvalid, 1);
        m_tready = 1'b1;
        @(posedge clk);
        #1 m_tready = 1'b0;
        send_beat({8{32'hDEAD_0001}}, 32'hFFFF_FFFF, 1'b0);
        axi_resetn = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rst_s_tready", s_tready, 0);
        check("t6_rst_m_tvalid", m_tvalid, 0);
        check("t6_rst_m_tlast", m_tlast, 0);
        check("t6_rst_m_tuser", m_tuser, 0);
        check("t6_rst_drop_count", drop_count, 0);
        @(posedge clk);
        #1;
        check("t6_rst_hold_tready", s_tready, 0);
        repeat (2) @(posedge clk);
        #1 axi_resetn = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rel_s_tready", s_tready, 1);
        m_tready = 1'b1;
        send_pkt(61, 2, 32'h0000_00FF, 40, 1);
        wait_drain("t6_drain");
        repeat (5) @(posedge clk);
        #1;
        check("t6_idle_after", m_tvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
